// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential advance, conditional branch/jump, CALL/RET
// through a small return-address stack, one-cycle flush bubble after every redirect.
module pc_sequencer #(
    parameter int                WIDTH     = 16,
    parameter int                DISP_W    = 8,
    parameter int                RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0]  RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              stall,
    input  logic [7:0]        op,
    input  logic [3:0]        cond,
    input  logic [DISP_W-1:0] disp,
    input  logic [WIDTH-1:0]  target,
    input  logic [4:0]        flags,
    output logic [WIDTH-1:0]  pc,
    output logic              taken,
    output logic              flush,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              fault
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             taken_reg, taken_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             push;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    logic             is_bcond, is_jcond, is_call, is_ret, cond_ok;
    logic             stack_full, stack_empty;
    logic [WIDTH-1:0] pc_plus1, pc_branch, ras_top;
    logic [AW-1:0]    top_idx, push_idx;

    // flags: [0]=C [1]=L [2]=F [3]=Z [4]=N
    function automatic logic cond_met(input logic [3:0] c, input logic [4:0] f);
        logic res;
        case (c)
            4'h0:    res = f[3];
            4'h1:    res = !f[3];
            4'h2:    res = f[0];
            4'h3:    res = !f[0];
            4'h4:    res = f[1];
            4'h5:    res = !f[1];
            4'h6:    res = f[4];
            4'h7:    res = !f[4];
            4'h8:    res = f[2];
            4'h9:    res = !f[2];
            4'hA:    res = !f[1] && !f[3];
            4'hB:    res = f[1] || f[3];
            4'hC:    res = !f[4] && !f[3];
            4'hD:    res = f[4] || f[3];
            4'hE:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign is_bcond    = (op[7:4] == 4'hC);
    assign is_jcond    = (op == 8'h4C);
    assign is_call     = (op == 8'h48);
    assign is_ret      = (op == 8'h49);
    assign cond_ok     = cond_met(cond, flags);

    assign stack_full  = (count_reg == CW'(RAS_DEPTH));
    assign stack_empty = (count_reg == '0);
    assign pc_plus1    = pc_reg + WIDTH'(1);
    assign pc_branch   = pc_reg + WIDTH'($signed(disp));
    assign top_idx     = AW'(count_reg - CW'(1));
    assign push_idx    = AW'(count_reg);
    // Small stack: combinational read so RET can redirect in the same cycle.
    assign ras_top     = ras_mem[top_idx];

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        taken_next = taken_reg;
        count_next = count_reg;
        push       = 1'b0;
        if (!stall) begin
            case (state_reg)
                ST_RUN: begin
                    taken_next = 1'b0;
                    if (en) begin
                        if ((is_call && stack_full) || (is_ret && stack_empty)) begin
                            state_next = ST_FAULT;
                        end else if (is_call) begin
                            push       = 1'b1;
                            count_next = count_reg + CW'(1);
                            pc_next    = target;
                            taken_next = 1'b1;
                            state_next = ST_FLUSH;
                        end else if (is_ret) begin
                            count_next = count_reg - CW'(1);
                            pc_next    = ras_top;
                            taken_next = 1'b1;
                            state_next = ST_FLUSH;
                        end else if (is_bcond && cond_ok) begin
                            pc_next    = pc_branch;
                            taken_next = 1'b1;
                            state_next = ST_FLUSH;
                        end else if (is_jcond && cond_ok) begin
                            pc_next    = target;
                            taken_next = 1'b1;
                            state_next = ST_FLUSH;
                        end else begin
                            pc_next    = pc_plus1;
                        end
                    end
                end
                ST_FLUSH: begin
                    taken_next = 1'b0;
                    state_next = ST_RUN;
                end
                default: begin
                    taken_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_RUN;
            pc_reg    <= RESET_PC;
            taken_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            taken_reg <= taken_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            ras_mem[push_idx] <= pc_plus1;
        end
    end

    assign pc        = pc_reg;
    assign taken     = taken_reg;
    assign flush     = (state_reg == ST_FLUSH);
    assign fault     = (state_reg == ST_FAULT);
    assign ras_full  = stack_full;
    assign ras_empty = stack_empty;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model compared every cycle,
// plus literal expectations on the key directed scenarios.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, stall;
    logic [7:0]  op;
    logic [3:0]  cond;
    logic [7:0]  disp;
    logic [15:0] target;
    logic [4:0]  flags;
    logic [15:0] pc;
    logic        taken, flush, ras_full, ras_empty, fault;

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(
        .WIDTH(16), .DISP_W(8), .RAS_DEPTH(4), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .op(op), .cond(cond),
        .disp(disp), .target(target), .flags(flags), .pc(pc), .taken(taken),
        .flush(flush), .ras_full(ras_full), .ras_empty(ras_empty), .fault(fault)
    );

    // Reference model: mode 0=run, 1=bubble, 2=faulted; stack is a queue.
    logic [15:0] m_pc;
    logic [15:0] m_stack [$];
    int          m_mode;
    logic        m_taken;
    bit          m_valid = 0;

    // Conditions come in complementary pairs: cond[3:1] picks a predicate, cond[0] inverts it.
    function automatic bit m_cond(input logic [3:0] c, input logic [4:0] f);
        bit cf, lf, ff, zf, nf, p;
        cf = f[0]; lf = f[1]; ff = f[2]; zf = f[3]; nf = f[4];
        case (c[3:1])
            3'd0:    p = zf;
            3'd1:    p = cf;
            3'd2:    p = lf;
            3'd3:    p = nf;
            3'd4:    p = ff;
            3'd5:    p = !lf && !zf;
            3'd6:    p = !nf && !zf;
            default: p = 1'b1;
        endcase
        return p ^ c[0];
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_pc    = 16'h0000;
            m_stack.delete();
            m_mode  = 0;
            m_taken = 1'b0;
            m_valid = 1;
        end else if (m_valid && !stall) begin
            if (m_mode == 1) begin
                m_mode  = 0;
                m_taken = 1'b0;
            end else if (m_mode == 2) begin
                m_taken = 1'b0;
            end else begin
                m_taken = 1'b0;
                if (en) begin
                    if (op == 8'h48) begin
                        if (m_stack.size() == 4) m_mode = 2;
                        else begin
                            m_stack.push_back(m_pc + 16'd1);
                            m_pc = target; m_taken = 1'b1; m_mode = 1;
                        end
                    end else if (op == 8'h49) begin
                        if (m_stack.size() == 0) m_mode = 2;
                        else begin
                            m_pc = m_stack.pop_back();
                            m_taken = 1'b1; m_mode = 1;
                        end
                    end else if (op[7:4] == 4'hC && m_cond(cond, flags)) begin
                        m_pc = m_pc + 16'($signed(disp)); m_taken = 1'b1; m_mode = 1;
                    end else if (op == 8'h4C && m_cond(cond, flags)) begin
                        m_pc = target; m_taken = 1'b1; m_mode = 1;
                    end else begin
                        m_pc = m_pc + 16'd1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [20:0] act, exp;
        if (m_valid) begin
            exp = {m_pc, m_taken, (m_mode == 1), (m_mode == 2),
                   (m_stack.size() == 4), (m_stack.size() == 0)};
            act = {pc, taken, flush, fault, ras_full, ras_empty};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL model_compare t=%0t pc/taken/flush/fault/full/empty actual=%h/%b%b%b%b%b required=%h/%b%b%b%b%b",
                         $time, act[20:5], act[4], act[3], act[2], act[1], act[0],
                         exp[20:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
            end
        end
    end

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic s, input logic [7:0] o,
                       input logic [3:0] c, input logic [7:0] d, input logic [15:0] t,
                       input logic [4:0] f);
        reset = r; en = e; stall = s; op = o; cond = c; disp = d; target = t; flags = f;
        @(posedge clk);
        @(negedge clk);
        $display("txn rst=%b en=%b stall=%b op=%h cond=%h disp=%h tgt=%h flg=%b -> pc=%h tk=%b fl=%b ft=%b full=%b empty=%b",
                 r, e, s, o, c, d, t, f, pc, taken, flush, fault, ras_full, ras_empty);
    endtask

    task automatic jmp(input logic [15:0] t);
        cyc(1, 1, 0, 8'h4C, 4'hE, 8'h00, t, 5'b0);
    endtask
    task automatic bub();
        cyc(1, 0, 0, 8'h00, 4'h0, 8'h00, 16'h0, 5'b0);
    endtask
    task automatic call(input logic [15:0] t);
        cyc(1, 1, 0, 8'h48, 4'h0, 8'h00, t, 5'b0);
    endtask
    task automatic ret();
        cyc(1, 1, 0, 8'h49, 4'h0, 8'h00, 16'h0, 5'b0);
    endtask
    task automatic rst();
        cyc(0, 0, 0, 8'h00, 4'h0, 8'h00, 16'h0, 5'b0);
    endtask

    logic [4:0] flag_set [3];

    initial begin
        reset = 1'b0; en = 1'b0; stall = 1'b0; op = 8'h00; cond = 4'h0;
        disp = 8'h00; target = 16'h0; flags = 5'b0;
        flag_set[0] = 5'b10101; flag_set[1] = 5'b01010; flag_set[2] = 5'b00000;
        @(negedge clk);
        rst(); rst();
        lit("reset_pc", pc, 16'h0000);
        lit("reset_empty", {15'b0, ras_empty}, 16'h1);
        lit("reset_tk_fl_ft_full", {12'b0, taken, flush, fault, ras_full}, 16'h0);

        // Redirect, then a CALL during the bubble must be ignored.
        jmp(16'h0010);
        lit("jmp_pc", pc, 16'h0010);
        call(16'h0999);
        lit("bubble_ignores_call_pc", pc, 16'h0010);
        lit("bubble_ignores_call_empty", {15'b0, ras_empty}, 16'h1);

        // Backward branch EQ with Z=1, disp=-2.
        cyc(1, 1, 0, 8'hC0, 4'h0, 8'hFE, 16'h0, 5'b01000);
        lit("beq_pc", pc, 16'h000E);
        lit("beq_taken", {15'b0, taken}, 16'h1);
        lit("beq_flush", {15'b0, flush}, 16'h1);
        bub();
        lit("beq_after_flush", {14'b0, flush, taken}, 16'h0);

        // All conditions under three flag patterns.
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 16; c++) begin
                cyc(1, 1, 0, 8'hC3, 4'(c), 8'h03, 16'h0, flag_set[p]);
                bub();
            end
        end
        bub(); bub();

        // Wrap-around and a never-taken jump.
        jmp(16'hFFFF); bub();
        cyc(1, 1, 0, 8'h12, 4'h0, 8'h00, 16'h0, 5'b0);
        lit("wrap_pc", pc, 16'h0000);
        jmp(16'h0005); bub();
        cyc(1, 1, 0, 8'h4C, 4'hF, 8'h00, 16'h1234, 5'b0);
        lit("jnever_pc", pc, 16'h0006);
        lit("jnever_taken", {15'b0, taken}, 16'h0);

        // CALL then RET.
        jmp(16'h0020); bub();
        call(16'h0100);
        lit("call_pc", pc, 16'h0100);
        lit("call_empty", {15'b0, ras_empty}, 16'h0);
        bub();
        ret();
        lit("ret_pc", pc, 16'h0021);
        lit("ret_empty", {15'b0, ras_empty}, 16'h1);
        bub();

        // Stall held during a bubble.
        jmp(16'h0040);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 8'h48, 4'h0, 8'h00, 16'h0777, 5'b0);
        lit("stall_pc", pc, 16'h0040);
        lit("stall_flush_taken", {14'b0, flush, taken}, 16'h3);
        cyc(1, 1, 0, 8'h48, 4'h0, 8'h00, 16'h0777, 5'b0);
        lit("stall_exit_flush", {15'b0, flush}, 16'h0);
        lit("stall_exit_pc", pc, 16'h0040);

        // Overflowing the stack faults.
        call(16'h0200); bub();
        call(16'h0300); bub();
        call(16'h0400); bub();
        call(16'h0500); bub();
        lit("stack_full", {15'b0, ras_full}, 16'h1);
        call(16'h0600);
        lit("overflow_fault", {15'b0, fault}, 16'h1);
        lit("overflow_pc", pc, 16'h0500);
        ret(); jmp(16'h0abc); bub();
        lit("fault_sticky_pc", pc, 16'h0500);
        lit("fault_sticky", {15'b0, fault}, 16'h1);
        rst();
        lit("fault_cleared", {14'b0, fault, ras_empty}, 16'h1);

        // LIFO order, then RET on an empty stack.
        call(16'h0200); bub();
        call(16'h0300); bub();
        ret();
        lit("lifo_ret1", pc, 16'h0201);
        bub();
        ret();
        lit("lifo_ret2", pc, 16'h0001);
        bub();
        ret();
        lit("underflow_fault", {15'b0, fault}, 16'h1);
        lit("underflow_pc", pc, 16'h0001);

        // Reset while stalled mid-bubble.
        rst();
        jmp(16'h0077);
        cyc(0, 1, 1, 8'h00, 4'h0, 8'h00, 16'h0, 5'b0);
        lit("reset_mid_flush_pc", pc, 16'h0000);
        lit("reset_mid_flush_fl_tk", {14'b0, flush, taken}, 16'h0);
        bub();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
